// File: rtl/cuadrante_pkg.sv
// Shared types and helpers for the frame-synchronous section scheduler.
// Section values are 3 bits wide; sec_inc/sec_dec wrap modulo n.
package cuadrante_pkg;

  typedef enum logic {S_IDLE, S_PEND} sched_state_t;

  typedef logic [2:0] seccion_t;

  localparam int NUM_SECTIONS_DEF = 5;

  function automatic seccion_t sec_inc(seccion_t s, int n);
    if (int'(s) >= n - 1) return '0;
    return s + 3'd1;
  endfunction

  function automatic seccion_t sec_dec(seccion_t s, int n);
    if (s == '0) return seccion_t'(n - 1);
    return s - 3'd1;
  endfunction

endpackage

// File: rtl/cuadrante_scheduler_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, and a
// one-cycle pulse on each accepted press. Ports: clk, reset, btn_i, pulse_o.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          pulse_q;
  logic [CW-1:0] cnt_q;

  // The count only runs while the synchronized level disagrees with the
  // accepted level; any bounce back restarts it. The pulse is registered
  // together with the stable level, so only releases stay silent.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      pulse_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CMAX) begin
        cnt_q    <= '0;
        stable_q <= sync2_q;
        pulse_q  <= sync2_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/cuadrante_scheduler.sv
// Section sequencer: queues advances from button/auto counter and applies
// them on frame_tick. Inputs: clk, reset, btn_next, auto_en, frame_tick
// (btn_prev when CUAD_PREV_BTN_EN is defined). Outputs: cuadrante_actual,
// cuadrante_pend, pendiente, cambio.
module cuadrante_scheduler
  import cuadrante_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FRAMES_PER_STEP = 60,
  parameter int NUM_SECTIONS    = NUM_SECTIONS_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
`ifdef CUAD_PREV_BTN_EN
  input  logic       btn_prev,
`endif
  input  logic       auto_en,
  input  logic       frame_tick,
  output logic [2:0] cuadrante_actual,
  output logic [2:0] cuadrante_pend,
  output logic       pendiente,
  output logic       cambio
);

  localparam int FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FW-1:0] FMAX = FW'(FRAMES_PER_STEP - 1);

  sched_state_t  state_q, state_d;
  seccion_t      act_q, act_d;
  seccion_t      pend_q, pend_d;
  logic          cambio_q, cambio_d;
  logic [FW-1:0] fcnt_q;

  logic     adv_btn;
  logic     adv_auto;
  logic     adv;
  logic     inc;
  logic     dec;
  logic     step;
  seccion_t base;
  seccion_t nxt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_next (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_next),
    .pulse_o(adv_btn)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt_q <= '0;
    end else if (!auto_en) begin
      fcnt_q <= '0;
    end else if (frame_tick) begin
      fcnt_q <= (fcnt_q == FMAX) ? '0 : fcnt_q + 1'b1;
    end
  end

  assign adv_auto = auto_en & frame_tick & (fcnt_q == FMAX);
  assign adv      = adv_btn | adv_auto;

`ifdef CUAD_PREV_BTN_EN
  logic adv_prev;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_prev (
    .clk    (clk),
    .reset  (reset),
    .btn_i  (btn_prev),
    .pulse_o(adv_prev)
  );

  // Next and prev in the same cycle cancel out.
  assign inc = adv & ~adv_prev;
  assign dec = adv_prev & ~adv;
`else
  assign inc = adv;
  assign dec = 1'b0;
`endif

  assign step = inc | dec;

  // Pending value builds on actual in IDLE and on itself in PEND.
  assign base = (state_q == S_PEND) ? pend_q : act_q;

  always_comb begin
    nxt = base;
    if (inc) nxt = sec_inc(base, NUM_SECTIONS);
    else if (dec) nxt = sec_dec(base, NUM_SECTIONS);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      act_q    <= '0;
      pend_q   <= '0;
      cambio_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      act_q    <= act_d;
      pend_q   <= pend_d;
      cambio_q <= cambio_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (step && !frame_tick) state_d = S_PEND;
      S_PEND: if (frame_tick) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A tick applies whatever is queued, including a same-cycle advance,
  // so an auto advance lands in the frame whose tick produced it.
  always_comb begin
    act_d    = act_q;
    pend_d   = pend_q;
    cambio_d = 1'b0;
    if (step) pend_d = nxt;
    if (frame_tick && (state_q == S_PEND || step)) begin
      act_d    = nxt;
      pend_d   = nxt;
      cambio_d = 1'b1;
    end
  end

  assign cuadrante_actual = act_q;
  assign cuadrante_pend   = pend_q;
  assign pendiente        = (state_q == S_PEND) && (pend_q != act_q);
  assign cambio           = cambio_q;

endmodule

// File: tb/tb_cuadrante_scheduler.sv
// Directed bench for cuadrante_scheduler with small debounce/frame params.
// Prints one summary line with error and check counts.
module tb_cuadrante_scheduler;

  logic       clk;
  logic       reset;
  logic       btn_next;
  logic       auto_en;
  logic       frame_tick;
  logic [2:0] cuadrante_actual;
  logic [2:0] cuadrante_pend;
  logic       pendiente;
  logic       cambio;

  int nerr;
  int nchk;

  cuadrante_scheduler #(
    .DEBOUNCE_CYCLES(4),
    .FRAMES_PER_STEP(3),
    .NUM_SECTIONS   (5)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .btn_next        (btn_next),
    .auto_en         (auto_en),
    .frame_tick      (frame_tick),
    .cuadrante_actual(cuadrante_actual),
    .cuadrante_pend  (cuadrante_pend),
    .pendiente       (pendiente),
    .cambio          (cambio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    btn_next   = 1'b0;
    auto_en    = 1'b0;
    frame_tick = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic press();
    btn_next = 1'b1;
    repeat (8) tick();
    btn_next = 1'b0;
    repeat (8) tick();
  endtask

  task automatic frame();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    tick();
  endtask

  initial begin
    nerr = 0;
    nchk = 0;

    // Reset state and single press latency.
    do_reset();
    chk("rst_act", int'(cuadrante_actual), 0);
    chk("rst_pend", int'(cuadrante_pend), 0);
    chk("rst_pendiente", int'(pendiente), 0);
    chk("rst_cambio", int'(cambio), 0);

    btn_next = 1'b1;
    repeat (6) tick();
    chk("lat_c6_pend", int'(cuadrante_pend), 0);
    tick();
    chk("lat_c7_pend", int'(cuadrante_pend), 1);
    chk("lat_c7_pendiente", int'(pendiente), 1);
    chk("lat_c7_act", int'(cuadrante_actual), 0);
    repeat (3) tick();
    btn_next = 1'b0;
    repeat (9) tick();
    chk("c19_pend_release", int'(cuadrante_pend), 1);
    chk("c19_act", int'(cuadrante_actual), 0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("c20_act", int'(cuadrante_actual), 1);
    chk("c20_cambio", int'(cambio), 1);
    chk("c20_pendiente", int'(pendiente), 0);
    tick();
    chk("c21_cambio", int'(cambio), 0);

    // Bounce 1,0,1,0 then held high.
    do_reset();
    btn_next = 1'b1; tick();
    btn_next = 1'b0; tick();
    btn_next = 1'b1; tick();
    btn_next = 1'b0; tick();
    btn_next = 1'b1;
    repeat (12) tick();
    btn_next = 1'b0;
    repeat (10) tick();
    chk("bounce_pend", int'(cuadrante_pend), 1);
    chk("bounce_pendiente", int'(pendiente), 1);
    frame();
    chk("bounce_act", int'(cuadrante_actual), 1);

    // Three presses accumulate into one step.
    do_reset();
    press();
    press();
    press();
    chk("acc_pend", int'(cuadrante_pend), 3);
    chk("acc_act_before", int'(cuadrante_actual), 0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("acc_act", int'(cuadrante_actual), 3);
    chk("acc_cambio", int'(cambio), 1);

    // Automatic advance every third tick, wrapping after 15 ticks.
    do_reset();
    auto_en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      repeat (49) tick();
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      chk($sformatf("auto_t%0d", i), int'(cuadrante_actual), (i / 3) % 5);
      if (i == 3) chk("auto_t3_cambio", int'(cambio), 1);
      if (i == 4) chk("auto_t4_cambio", int'(cambio), 0);
    end

    // Button and auto advance on the same tick count once.
    do_reset();
    auto_en = 1'b1;
    repeat (8) frame();
    chk("coin_pre_act", int'(cuadrante_actual), 2);
    btn_next = 1'b1;
    repeat (6) tick();
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("coin_act", int'(cuadrante_actual), 3);
    chk("coin_cambio", int'(cambio), 1);
    chk("coin_pendiente", int'(pendiente), 0);
    btn_next = 1'b0;
    repeat (10) tick();
    chk("coin_act_hold", int'(cuadrante_actual), 3);

    // Reset discards a pending request.
    do_reset();
    press();
    press();
    chk("rp_pend", int'(cuadrante_pend), 2);
    chk("rp_pendiente", int'(pendiente), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rp_act", int'(cuadrante_actual), 0);
    chk("rp_pend0", int'(cuadrante_pend), 0);
    chk("rp_pendiente0", int'(pendiente), 0);
    frame_tick = 1'b1;
    tick();
    frame_tick = 1'b0;
    chk("rp_cambio", int'(cambio), 0);
    chk("rp_act_tick", int'(cuadrante_actual), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/cuadrante_scheduler.md
Name: cuadrante_scheduler

Overview:
- Frame-synchronous section sequencer for the VGA painter.
- Selects which screen section is active: section 0 is full screen, sections 1-4 are the quadrants.
- Advance sources: debounced push-button and/or an automatic frame counter.
- The applied section changes only on the frame_tick pulse, so a frame never tears. Output drives the painter's section-select input in place of the raw-button FSM.

Parameters:
- DEBOUNCE_CYCLES, 500000: clk cycles the synchronized button must stay stable before it is accepted (10 ms at 50 MHz).
- FRAMES_PER_STEP, 60: frames between automatic advances when auto_en=1.
- NUM_SECTIONS, 5: number of sections; legal values 0..NUM_SECTIONS-1; must be 2..8.

Ports:
- clk  in  1  system clock (50 MHz)
- reset  in  1  synchronous, active-high reset
- btn_next  in  1  raw asynchronous push-button, active-high
- auto_en  in  1  level; 1 enables automatic advance
- frame_tick  in  1  one-cycle pulse at start of vertical blank (from sync generator)
- cuadrante_actual  out  3  section currently applied to the painter
- cuadrante_pend  out  3  section that will be applied at next frame_tick
- pendiente  out  1  1 while cuadrante_pend differs from cuadrante_actual
- cambio  out  1  one-cycle pulse in the cycle cuadrante_actual updates

Behaviour:
- Interface (already decided): one clock, clk. reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: cuadrante_actual=0, cuadrante_pend=0, pendiente=0, cambio=0. Debounce counter, frame counter and synchronizer flops are cleared. The stable button level resets to 0.
- Button path: 2-flop synchronizer, then debounce counter.
  - Counter restarts whenever the synchronized level differs from the stable level.
  - When it reaches DEBOUNCE_CYCLES-1 the stable level takes the new value.
  - A 0->1 transition of the stable level produces one-cycle adv_btn.
  - Press-to-adv_btn latency: 2 + DEBOUNCE_CYCLES cycles.
  - Release generates nothing.
- Auto path: frame counter 0..FRAMES_PER_STEP-1 increments on each frame_tick while auto_en=1.
  - On the frame_tick that finds the counter at FRAMES_PER_STEP-1, the counter wraps to 0 and adv_auto pulses in the same cycle.
  - auto_en=0 holds the counter at 0.
- Advance request adv = adv_btn OR adv_auto. Simultaneous pulses count as one advance.
- FSM, states IDLE and PEND:
  - IDLE: on adv, cuadrante_pend <= cuadrante_actual+1 (wrap NUM_SECTIONS-1 -> 0); go to PEND.
  - PEND: on adv, cuadrante_pend <= cuadrante_pend+1 (wrap). Multiple presses within one frame accumulate.
  - PEND, frame_tick: cuadrante_actual <= cuadrante_pend (including the same-cycle increment if adv is also high, i.e. the post-increment value); cambio=1; go to IDLE.
  - IDLE, adv and frame_tick same cycle: the pending value is computed and applied immediately, cuadrante_actual <= cuadrante_actual+1; cambio=1; stay IDLE. An auto advance therefore lands in the frame whose tick generated it.
- Accumulated wrap to the same value (e.g. NUM_SECTIONS presses): applied on frame_tick anyway. cambio pulses; cuadrante_actual is unchanged.
- pendiente is combinational: (state==PEND) && (cuadrante_pend != cuadrante_actual).
- Reset mid-debounce or in PEND: the pending request is discarded and all state returns to reset values.

Optional Feature:
- Macro CUAD_PREV_BTN_EN.
- Defined: adds input btn_prev (1 bit) with its own synchronizer and debounce, producing adv_prev.
  - adv_prev decrements the pending value (0 wraps to NUM_SECTIONS-1).
  - Same cycle as adv: net zero, no state change.
- Undefined: port and logic absent; behaviour exactly as above.

Decomposition:
- Package cuadrante_pkg:
  - typedef enum logic {S_IDLE, S_PEND} sched_state_t;
  - typedef logic [2:0] seccion_t;
  - localparam NUM_SECTIONS_DEF=5.
  - function seccion_t sec_inc(seccion_t s, int n), and sec_dec likewise.
- Sub-module btn_debounce (synchronizer + counter + rising-edge pulse), parameter DEBOUNCE_CYCLES. Instantiated once, or twice with CUAD_PREV_BTN_EN.

Test Plan (DEBOUNCE_CYCLES=4, FRAMES_PER_STEP=3, NUM_SECTIONS=5):
- Reset then btn_next high for 10 cycles, frame_tick at cycle 20 -> pendiente=1, cuadrante_pend=1 from cycle 7. At cycle 20, cuadrante_actual=1, cambio one cycle, pendiente=0.
- Button bounce 1,0,1,0 each 1 cycle then stable 1 -> exactly one advance (cuadrante_pend=1).
- Three clean presses before one frame_tick, starting actual=0 -> cuadrante_pend=3, then actual 0->3 in a single step.
- auto_en=1, frame_tick every 50 cycles -> actual goes 0,0,1,1,1,2,... advancing on the 3rd, 6th, 9th ticks; after 15 ticks actual wraps 4->0.
- adv_btn and adv_auto coincide on a frame_tick with actual=2 -> actual=3, not 4.
- Press accepted (PEND, pend=2), reset asserted for 1 cycle before frame_tick -> actual=0, pend=0, pendiente=0, no cambio on next tick.
